// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - valid/ready payload handshake bundle for pipe_stage_buf
interface pipe_stage_buf_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  // Producer side: offers valid/data, observes ready.
  modport master (output valid, output data, input ready);
  // Consumer side: observes valid/data, answers with ready.
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic DEPTH-entry pipeline stage register; optional counters under STAGE_STATS_EN
module pipe_stage_buf #(
  parameter int                DATA_W  = 64,
  parameter int                DEPTH   = 2,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int               CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  pipe_stage_buf_if.slave    in_if,
  pipe_stage_buf_if.master   out_if,
  output logic [CNT_W-1:0]   level
`ifdef STAGE_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // Handshake qualifiers; in_ready looks only at registered state so no
  // combinational path exists from out_ready back to the producer.
  always_comb begin
    in_ready  = ~rst & ~freeze & (count_q < CNT_FULL);
    out_valid = (count_q != '0);
    push      = in_if.valid & in_ready & ~flush;
    pop       = out_valid & out_if.ready & ~freeze & ~flush;
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_valid ? mem_q[rd_ptr_q] : RST_VAL;
  assign level        = count_q;

  // Next pointer/occupancy: flush wins over everything, freeze already
  // suppresses push and pop so it needs no branch of its own.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are meaningless while count says empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_if.data;
    end
  end

`ifdef STAGE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: producer blocked, and flushes that drop data.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (in_if.valid && !in_ready && !rst && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush && (count_q != '0) && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - checks pipe_stage_buf at DEPTH 2, 1 and 3 against a list model
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, flush, in_valid, out_ready;
  logic [63:0] in_data;

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.DATA_W(64)) i0 (), o0 (), i1 (), o1 (), i2 (), o2 ();

  assign i0.valid = in_valid;  assign i0.data = in_data;  assign o0.ready = out_ready;
  assign i1.valid = in_valid;  assign i1.data = in_data;  assign o1.ready = out_ready;
  assign i2.valid = in_valid;  assign i2.data = in_data;  assign o2.ready = out_ready;

  logic [1:0] lv0;
  logic [0:0] lv1;
  logic [1:0] lv2;
`ifdef STAGE_STATS_EN
  logic [15:0] sc [3];
  logic [15:0] fc [3];
`endif

  pipe_stage_buf #(.DATA_W(64), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_if(i0), .out_if(o0), .level(lv0)
`ifdef STAGE_STATS_EN
    , .stall_cnt(sc[0]), .flush_cnt(fc[0])
`endif
  );

  pipe_stage_buf #(.DATA_W(64), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_if(i1), .out_if(o1), .level(lv1)
`ifdef STAGE_STATS_EN
    , .stall_cnt(sc[1]), .flush_cnt(fc[1])
`endif
  );

  pipe_stage_buf #(.DATA_W(64), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_if(i2), .out_if(o2), .level(lv2)
`ifdef STAGE_STATS_EN
    , .stall_cnt(sc[2]), .flush_cnt(fc[2])
`endif
  );

  logic        a_ov [3];
  logic        a_ir [3];
  logic [63:0] a_od [3];
  int          a_lv [3];

  assign a_ov[0] = o0.valid;  assign a_ir[0] = i0.ready;  assign a_od[0] = o0.data;  assign a_lv[0] = int'(lv0);
  assign a_ov[1] = o1.valid;  assign a_ir[1] = i1.ready;  assign a_od[1] = o1.data;  assign a_lv[1] = int'(lv1);
  assign a_ov[2] = o2.valid;  assign a_ir[2] = i2.ready;  assign a_od[2] = o2.data;  assign a_lv[2] = int'(lv2);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        frz;
    logic        fl;
    logic        iv;
    logic [63:0] din;
    logic        ory;
    logic        e_ov;
    logic [63:0] e_od;
    int          e_lv;
    logic        e_ir;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];

  // Behavioural model: an ordered list per instance, head at index 0.
  int          dep  [3] = '{2, 1, 3};
  int          msz  [3];
  logic [63:0] mdat [3][16];
  int          m_stall [3];
  int          m_flush [3];

  initial begin
    logic [63:0] A, B, C, D, E, F, G, H, X;
    A = 64'hAAAA_0000_0000_0001;  B = 64'hBBBB_0000_0000_0002;
    C = 64'hCCCC_0000_0000_0003;  D = 64'hDDDD_0000_0000_0004;
    E = 64'hEEEE_0000_0000_0005;  F = 64'hFFFF_0000_0000_0006;
    G = 64'h1111_0000_0000_0007;  H = 64'h2222_0000_0000_0008;
    X = 64'hDEAD_0004_1234_5678;

    //          frz  fl   iv   din  ory   e_ov e_od e_lv e_ir
    tv[0]  = '{1'b0,1'b0,1'b1, X,   1'b1, 1'b1, X,   1, 1'b1};
    tv[1]  = '{1'b0,1'b0,1'b0, '0,  1'b1, 1'b0, '0,  0, 1'b1};
    tv[2]  = '{1'b0,1'b0,1'b1, A,   1'b0, 1'b1, A,   1, 1'b1};
    tv[3]  = '{1'b0,1'b0,1'b1, B,   1'b0, 1'b1, A,   2, 1'b0};
    tv[4]  = '{1'b0,1'b0,1'b1, C,   1'b0, 1'b1, A,   2, 1'b0};
    tv[5]  = '{1'b0,1'b0,1'b1, C,   1'b1, 1'b1, B,   1, 1'b1};
    tv[6]  = '{1'b0,1'b0,1'b1, C,   1'b1, 1'b1, C,   1, 1'b1};
    tv[7]  = '{1'b0,1'b0,1'b0, '0,  1'b1, 1'b0, '0,  0, 1'b1};
    tv[8]  = '{1'b0,1'b0,1'b1, D,   1'b0, 1'b1, D,   1, 1'b1};
    tv[9]  = '{1'b0,1'b0,1'b1, E,   1'b1, 1'b1, E,   1, 1'b1};
    tv[10] = '{1'b0,1'b0,1'b1, F,   1'b0, 1'b1, E,   2, 1'b0};
    tv[11] = '{1'b1,1'b0,1'b1, G,   1'b1, 1'b1, E,   2, 1'b0};
    tv[12] = '{1'b1,1'b0,1'b1, G,   1'b1, 1'b1, E,   2, 1'b0};
    tv[13] = '{1'b1,1'b0,1'b1, G,   1'b1, 1'b1, E,   2, 1'b0};
    tv[14] = '{1'b1,1'b1,1'b1, G,   1'b1, 1'b0, '0,  0, 1'b0};
    tv[15] = '{1'b0,1'b0,1'b0, '0,  1'b0, 1'b0, '0,  0, 1'b1};
    tv[16] = '{1'b0,1'b1,1'b1, H,   1'b0, 1'b0, '0,  0, 1'b1};
    tv[17] = '{1'b0,1'b0,1'b0, '0,  1'b0, 1'b0, '0,  0, 1'b1};

    rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ov",    64'(a_ov[0]), 64'd0);
    chk("reset_od",    a_od[0],      64'd0);
    chk("reset_level", 64'(a_lv[0]), 64'd0);
    chk("reset_ir",    64'(a_ir[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors on the DEPTH=2 instance.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      freeze = tv[i].frz; flush = tv[i].fl; in_valid = tv[i].iv;
      in_data = tv[i].din; out_ready = tv[i].ory;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ov", i),    64'(a_ov[0]), 64'(tv[i].e_ov));
      chk($sformatf("vec%0d_od", i),    a_od[0],      tv[i].e_od);
      chk($sformatf("vec%0d_level", i), 64'(a_lv[0]), 64'(tv[i].e_lv));
      chk($sformatf("vec%0d_ir", i),    64'(a_ir[0]), 64'(tv[i].e_ir));
    end
`ifdef STAGE_STATS_EN
    chk("flush_cnt_after_vectors", 64'(fc[0]), 64'd1);
`endif

    // Asynchronous reset in the middle of a transfer.
    @(negedge clk);
    freeze = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    @(negedge clk);
    in_data = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk);
    #3;
    chk("pre_rst_level", 64'(a_lv[0]), 64'd2);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_rst%0d_ov", k),    64'(a_ov[k]), 64'd0);
      chk($sformatf("async_rst%0d_od", k),    a_od[k],      64'd0);
      chk($sformatf("async_rst%0d_level", k), 64'(a_lv[k]), 64'd0);
      chk($sformatf("async_rst%0d_ir", k),    64'(a_ir[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_rst%0d_ir", k), 64'(a_ir[k]), 64'd1);
      chk($sformatf("post_rst%0d_ov", k), 64'(a_ov[k]), 64'd0);
    end

    // Randomised run of all three depths against the list model.
    for (int k = 0; k < 3; k++) begin
      msz[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      freeze    = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (cyc % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      in_data   = {$urandom, $urandom};
      #1;
      for (int k = 0; k < 3; k++) begin
        logic        e_ir, e_ov;
        logic [63:0] e_od;
        e_ir = !freeze && (msz[k] < dep[k]);
        e_ov = (msz[k] != 0);
        e_od = e_ov ? mdat[k][0] : 64'd0;
        chk($sformatf("rnd%0d_d%0d_ir", cyc, k),    64'(a_ir[k]), 64'(e_ir));
        chk($sformatf("rnd%0d_d%0d_ov", cyc, k),    64'(a_ov[k]), 64'(e_ov));
        chk($sformatf("rnd%0d_d%0d_od", cyc, k),    a_od[k],      e_od);
        chk($sformatf("rnd%0d_d%0d_level", cyc, k), 64'(a_lv[k]), 64'(msz[k]));
`ifdef STAGE_STATS_EN
        chk($sformatf("rnd%0d_d%0d_stall", cyc, k), 64'(sc[k]), 64'(m_stall[k]));
        chk($sformatf("rnd%0d_d%0d_flush", cyc, k), 64'(fc[k]), 64'(m_flush[k]));
`endif
        if (in_valid && !e_ir && m_stall[k] < 65535) m_stall[k]++;
        if (flush && msz[k] != 0 && m_flush[k] < 65535) m_flush[k]++;
        if (flush) begin
          msz[k] = 0;
        end else if (!freeze) begin
          if (e_ov && out_ready) begin
            for (int j = 1; j < msz[k]; j++) mdat[k][j-1] = mdat[k][j];
            msz[k]--;
          end
          if (in_valid && e_ir) begin
            mdat[k][msz[k]] = in_data;
            msz[k]++;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline-stage register, the successor of the fixed IF/ID latch.
- Carries an arbitrary-width payload (PC + instruction, decoded control bundle, etc.) between two pipeline stages.
- Uses valid/ready handshakes and a DEPTH-entry circular buffer, so a stalled consumer no longer forces the producer to freeze on the same cycle.
- Keeps the existing freeze and flush controls with the same priority order: reset > flush > freeze.

Parameters:
DATA_W, 64, payload width in bits (1..512).
DEPTH, 2, number of storage entries (1..16; any integer, pointers wrap explicitly).
RST_VAL, 0, value driven on out_data when the buffer is empty and after reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
freeze  in  1  hazard stall; blocks both push and pop.
flush  in  1  synchronous kill; discards every held entry.
in_valid  in  1  producer has a payload.
in_data  in  DATA_W  producer payload.
in_ready  out  1  buffer accepts a payload this cycle.
out_valid  out  1  head entry present.
out_data  out  DATA_W  head entry payload.
out_ready  in  1  consumer takes the head entry.
level  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, rst=1): count=0, rd_ptr=wr_ptr=0, out_valid=0, out_data=RST_VAL, level=0, in_ready=0 while rst is high. Storage contents are don't-care.
- in_ready = ~rst & ~freeze & (count < DEPTH). It is combinational from registered state only; there is no comb path from out_ready.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~freeze & ~flush.
- Push writes mem[wr_ptr] and advances wr_ptr, wrapping DEPTH-1 -> 0.
- Pop advances rd_ptr with the same wrap.
- count next value: +1 on push only; -1 on pop only; unchanged on push and pop together, or on neither.
- Latency: a payload pushed at edge N is visible on out_data with out_valid=1 after edge N (1 cycle) if the buffer was empty; otherwise it follows FIFO order.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else RST_VAL. The output mux is registered-state driven only.
- Occupancy states, reported via level:
  - EMPTY (0): in_ready=1 unless freeze.
  - PARTIAL (1..DEPTH-1): push and pop both allowed.
  - FULL (DEPTH): in_ready=0; a pop in FULL frees space, but in_ready only rises in the following cycle.
- Flush (sync): at the next edge count=0 and rd_ptr=wr_ptr=0; out_valid=0 after that edge. An in_valid payload in the same cycle is dropped. Flush overrides freeze.
- Freeze without flush: no state change at all; out_valid/out_data stay stable; out_ready is ignored.
- Simultaneous push and pop at count=1: the head advances and the new entry becomes the head; count stays 1.
- DEPTH=1 behaves exactly like the legacy latch with handshakes: in_ready=1 only when empty.
- rst asserted mid-transfer: all state cleared immediately, regardless of clk.

Optional Feature:
Macro STAGE_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0], both reset to 0 and saturating at 16'hFFFF.
  - stall_cnt increments each cycle with in_valid=1 & in_ready=0 & ~rst.
  - flush_cnt increments each cycle with flush=1 & count!=0, i.e. a flush that discards data.
- Undefined: the ports and counters are absent, and datapath behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with in_valid=1 -> out_valid=0, out_data=0, level=0, in_ready=0 immediately; in_ready=1 one cycle after rst falls.
- Latency: DEPTH=2, push 0xDEAD_0004_1234_5678 with out_ready=1 -> out_valid=1 with that value after 1 edge, then empty.
- Fill: out_ready=0, push A,B -> level=2, in_ready=0; C is held off. Set out_ready=1 -> A, B, C emerge in order, one per cycle; pointers wrap correctly.
- Concurrent: level=1 (A), push B and pop A same edge -> level stays 1, out_data=B.
- Freeze/flush: level=2, freeze=1 for 3 cycles with out_ready=1 -> out_data unchanged, level=2. Then flush=1 with freeze=1 and in_valid=1 -> level=0, out_valid=0, pushed value lost. With STAGE_STATS_EN, flush_cnt=1.
- DEPTH=1 build: back-to-back in_valid with out_ready toggling 1,0,1 -> in_ready follows empty state; no payload lost or duplicated (scoreboard check).
